reduce_or_seq_ctrl: RTL and testbench

- Multi-cycle controller that schedules a shared CHUNK-bit OR-reduce slice across a wide operand, one chunk per cycle.
- Input bits are classed by a per-bit constant mask and constant value.
- Resolves immediately when any constant bit is 1, or when every bit is constant.
- Otherwise scans only chunks that contain non-constant bits. Sits between a requester and the reduction result consumer, using valid/ready on both sides.

---
 rtl/reduce_or_seq_pkg.sv | 24 ++
 rtl/reduce_or_chunk_find.sv | 28 ++
 rtl/reduce_or_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_reduce_or_seq_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/reduce_or_seq_pkg.sv
// Shared types and elaboration-time helpers for the sequential OR-reduce controller.
package reduce_or_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned nchunk(input int unsigned a_width, input int unsigned chunk);
    return (a_width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/reduce_or_chunk_find.sv
// Finds the lowest live chunk strictly above idx_i, or the lowest live chunk overall when start_i is set.
module reduce_or_chunk_find #(
  parameter int unsigned NCHUNK = 4,
  parameter int unsigned IW     = 2
) (
  input  logic [NCHUNK-1:0] live_i,
  input  logic [IW-1:0]     idx_i,
  input  logic              start_i,
  output logic [IW-1:0]     nxt_o,
  output logic              found_o
);

  logic [31:0] idx_ext;

  // Descending walk so the last assignment wins with the lowest qualifying chunk.
  always_comb begin
    idx_ext = 32'(idx_i);
    nxt_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = NCHUNK; i > 0; i--) begin
      if (live_i[i-1] && (start_i || ((i - 1) > idx_ext))) begin
        nxt_o   = IW'(i - 1);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reduce_or_seq_ctrl.sv
// Multi-cycle OR-reduce controller scanning one CHUNK-bit slice per cycle.
// Define REDUCE_OR_SEQ_EARLY_EXIT_EN to finish a scan on the first chunk that hits.
module reduce_or_seq_ctrl
  import reduce_or_seq_pkg::*;
#(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned CHUNK   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [A_WIDTH-1:0] msk,
  input  logic [A_WIDTH-1:0] val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               y,
  output logic [clog2(nchunk(A_WIDTH, CHUNK) + 1)-1:0] nscan,
  output logic               busy
);

  localparam int unsigned NCHUNK = nchunk(A_WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned IW     = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam int unsigned NW     = clog2(NCHUNK + 1);
`ifdef REDUCE_OR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [PW-1:0]     am_q, am_d;
  logic [NCHUNK-1:0] live_q, live_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              acc_q, acc_d;
  logic              y_q, y_d;
  logic [NW-1:0]     nscan_q, nscan_d;

  logic [PW-1:0]     msk_p, am_new;
  logic [NCHUNK-1:0] live_new, live_sel;
  logic              start, found, hit;
  logic [IW-1:0]     nxt_idx;

  // Padding bits beyond A_WIDTH become constant zeros; only unmasked operand bits are kept.
  always_comb begin
    msk_p  = ~(PW'(~msk));
    am_new = PW'(a) & ~msk_p;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      live_new[c] = ~&msk_p[c*CHUNK +: CHUNK];
    end
  end

  assign start    = (state_q == IDLE);
  assign live_sel = start ? live_new : live_q;

  reduce_or_chunk_find #(
    .NCHUNK (NCHUNK),
    .IW     (IW)
  ) u_find (
    .live_i  (live_sel),
    .idx_i   (idx_q),
    .start_i (start),
    .nxt_o   (nxt_idx),
    .found_o (found)
  );

  always_comb begin
    hit = 1'b0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      if (idx_q == IW'(c)) hit = |am_q[c*CHUNK +: CHUNK];
    end
  end

  always_comb begin
    state_d = state_q;
    am_d    = am_q;
    live_d  = live_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    y_d     = y_q;
    nscan_d = nscan_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          am_d    = am_new;
          live_d  = live_new;
          acc_d   = 1'b0;
          nscan_d = '0;
          y_d     = 1'b0;
          if (|(msk & val)) begin
            state_d = DONE;
            y_d     = 1'b1;
          end else if (&msk) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = nxt_idx;
          end
        end
      end
      SCAN: begin
        acc_d   = acc_q | hit;
        nscan_d = nscan_q + NW'(1);
        if (EARLY_EXIT && hit) begin
          state_d = DONE;
          y_d     = 1'b1;
        end else if (found) begin
          idx_d = nxt_idx;
        end else begin
          state_d = DONE;
          y_d     = acc_q | hit;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      am_q    <= '0;
      live_q  <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      y_q     <= 1'b0;
      nscan_q <= '0;
    end else begin
      state_q <= state_d;
      am_q    <= am_d;
      live_q  <= live_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      nscan_q <= nscan_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign nscan     = nscan_q;

endmodule

// File: tb/tb_reduce_or_seq_ctrl.sv
// Directed and randomized checks of reduce_or_seq_ctrl (A_WIDTH=16, CHUNK=4) against a chunk-level model.
module tb_reduce_or_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, msk, val;
  logic        out_valid;
  logic        out_ready;
  logic        y;
  logic [2:0]  nscan;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reduce_or_seq_ctrl #(
    .A_WIDTH (16),
    .CHUNK   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .msk       (msk),
    .val       (val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .nscan     (nscan),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result and scan count from the rules: constants first, then walk live chunks in order.
  function automatic void model(input logic [15:0] ta, input logic [15:0] tm, input logic [15:0] tv,
                                output logic ey, output int en);
    int k;
    int first;
    logic [3:0] um;
    k = 0;
    first = 0;
    if ((tm & tv) != 16'h0) begin
      ey = 1'b1; en = 0; return;
    end
    if (tm == 16'hFFFF) begin
      ey = 1'b0; en = 0; return;
    end
    for (int c = 0; c < 4; c++) begin
      um = ~tm[c*4 +: 4];
      if (um != 4'h0) begin
        k++;
        if (((ta[c*4 +: 4] & um) != 4'h0) && first == 0) first = k;
      end
    end
    ey = (first != 0);
    en = k;
`ifdef REDUCE_OR_SEQ_EARLY_EXIT_EN
    if (first != 0) en = first;
`endif
  endfunction

  task automatic run_req(input logic [15:0] ta, input logic [15:0] tm, input logic [15:0] tv,
                         input bit bp, input string tag);
    logic ey;
    int   en;
    int   lat;
    model(ta, tm, tv, ey, en);
    out_ready = !bp;
    @(negedge clk);
    chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    a = ta; msk = tm; val = tv; in_valid = 1'b1;
    @(negedge clk);
    // Junk requests while busy must be ignored.
    in_valid = 1'b1; a = 16'($urandom); msk = 16'($urandom); val = 16'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "/latency"}, 32'(lat), 32'(en + 1));
    chk({tag, "/y"}, 32'(y), 32'(ey));
    chk({tag, "/nscan"}, 32'(nscan), 32'(en));
    chk({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
    chk({tag, "/busy_done"}, 32'(busy), 32'd1);
    if (bp) begin
      repeat (3) begin
        @(negedge clk);
        chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/hold_y"}, 32'(y), 32'(ey));
        chk({tag, "/hold_nscan"}, 32'(nscan), 32'(en));
        chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "/released_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "/released_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rm, rv;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; msk = '0; val = '0;
    repeat (2) @(negedge clk);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/y", 32'(y), 32'd0);
    chk("reset/nscan", 32'(nscan), 32'd0);
    rst = 1'b0;

    run_req(16'h0000, 16'h0000, 16'h0000, 1'b0, "all_zero");
    run_req(16'hFFFF, 16'h00F0, 16'h0010, 1'b0, "const_one");
    run_req(16'h1234, 16'hFFFF, 16'h0000, 1'b0, "all_const");
    run_req(16'h8000, 16'h0FF0, 16'h0000, 1'b0, "skip_mid");
    run_req(16'h0002, 16'h0000, 16'h0000, 1'b0, "low_hit");
    run_req(16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, "masked_bits_ignored");
    run_req(16'h0002, 16'h0000, 16'h0000, 1'b1, "backpressure_scan");
    run_req(16'h0000, 16'h0100, 16'h0100, 1'b1, "backpressure_const");

    // Reset in the middle of a scan.
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'h0000; msk = 16'h0000; val = 16'h0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midscan/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan/out_valid", 32'(out_valid), 32'd0);
    chk("midscan/in_ready", 32'(in_ready), 32'd1);
    chk("midscan/busy", 32'(busy), 32'd0);
    chk("midscan/nscan", 32'(nscan), 32'd0);
    run_req(16'h0040, 16'h0000, 16'h0000, 1'b0, "after_reset");

    for (int n = 0; n < 40; n++) begin
      rm = '0;
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 2))
          0:       rm[c*4 +: 4] = 4'h0;
          1:       rm[c*4 +: 4] = 4'hF;
          default: rm[c*4 +: 4] = 4'($urandom);
        endcase
      end
      ra = 16'($urandom & $urandom & $urandom);
      rv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      run_req(ra, rm, rv, ($urandom_range(0, 4) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
